// File: rtl/rl_writer_if.sv
// Byte handshake plus tape-line outputs for rl_writer; the writer sits on the slave side.
interface rl_writer_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       abort;
  logic [2:0] rl_signal;
  logic       busy;
  logic       end_seen;

  modport master (
    output data_in,
    output data_valid,
    output abort,
    input  data_ready,
    input  rl_signal,
    input  busy,
    input  end_seen
  );

  modport slave (
    input  data_in,
    input  data_valid,
    input  abort,
    output data_ready,
    output rl_signal,
    output busy,
    output end_seen
  );
endinterface

// File: rtl/rl_writer.sv
// Serialises bytes onto a strobed 2-bit tape line, MSB dibit first, each as a MARK/SPACE pair.
// Define RL_WRITER_PARITY_EN to append an even-parity dibit {0, ^byte} to every byte.
module rl_writer #(
  parameter int HOLD_CYCLES = 100000,
  parameter int GAP_CYCLES  = 100000
) (
  input logic        clk,
  input logic        rst_n,
  rl_writer_if.slave bus
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

`ifdef RL_WRITER_PARITY_EN
  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = 3'd4;
`else
  localparam int IDX_W = 2;
  localparam logic [IDX_W-1:0] LAST_IDX = 2'd3;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MARK  = 2'd1,
    S_SPACE = 2'd2,
    S_END   = 2'd3
  } state_t;

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [IDX_W-1:0] idx_q, idx_nxt;
  logic [7:0]       byte_q, byte_nxt;

  logic [2:0] rl_q, rl_nxt;
  logic       ready_q, ready_nxt;
  logic       busy_q, busy_nxt;
  logic       end_q, end_nxt;
  logic [7:0] shifted;
  logic [1:0] dibit_nxt;

  // State register; outputs are registered from the next-state values so they
  // change on the same edge as the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      byte_q  <= 8'h00;
      rl_q    <= 3'b000;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      idx_q   <= idx_nxt;
      byte_q  <= byte_nxt;
      rl_q    <= rl_nxt;
      ready_q <= ready_nxt;
      busy_q  <= busy_nxt;
      end_q   <= end_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    idx_nxt   = idx_q;
    byte_nxt  = byte_q;
    if (bus.abort) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.data_valid) begin
            state_nxt = S_MARK;
            byte_nxt  = bus.data_in;
            idx_nxt   = '0;
            cnt_nxt   = HOLD_LOAD;
          end
        end
        S_MARK: begin
          if (cnt_q == '0) begin
            state_nxt = S_SPACE;
            cnt_nxt   = GAP_LOAD;
          end else begin
            cnt_nxt = cnt_q - 1'b1;
          end
        end
        S_SPACE: begin
          if (cnt_q != '0) begin
            cnt_nxt = cnt_q - 1'b1;
          end else if (idx_q == LAST_IDX) begin
            state_nxt = (byte_q == 8'hFF) ? S_END : S_IDLE;
            idx_nxt   = '0;
          end else begin
            state_nxt = S_MARK;
            idx_nxt   = idx_q + 1'b1;
            cnt_nxt   = HOLD_LOAD;
          end
        end
        default: begin
          state_nxt = S_END;
        end
      endcase
    end
  end

  // Dibit i sits in bits [7-2i:6-2i]; shifting left by 2i brings it to the top.
  always_comb begin
    shifted   = byte_nxt << {idx_nxt[1:0], 1'b0};
    dibit_nxt = shifted[7:6];
`ifdef RL_WRITER_PARITY_EN
    if (idx_nxt == LAST_IDX) begin
      dibit_nxt = {1'b0, ^byte_nxt};
    end
`endif
    rl_nxt    = (state_nxt == S_MARK) ? {1'b1, dibit_nxt} : 3'b000;
    ready_nxt = (state_nxt == S_IDLE);
    busy_nxt  = (state_nxt != S_IDLE);
    end_nxt   = (state_nxt == S_END);
  end

  assign bus.rl_signal  = rl_q;
  assign bus.data_ready = ready_q;
  assign bus.busy       = busy_q;
  assign bus.end_seen   = end_q;

endmodule

// File: tb/tb_rl_writer.sv
// Randomised bench for rl_writer; expected tape sequences come from a per-byte symbol model.
module tb_rl_writer;
  localparam int HOLD = 4;
  localparam int GAP  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic [2:0] exp_q[$];

  rl_writer_if bus();

  rl_writer #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Expected tape line, one entry per cycle, starting the cycle after acceptance.
  task automatic build_expected(input logic [7:0] b);
    logic [1:0] dibits[$];
    exp_q.delete();
    for (int i = 3; i >= 0; i--) dibits.push_back(b[2*i +: 2]);
`ifdef RL_WRITER_PARITY_EN
    dibits.push_back({1'b0, ^b});
`endif
    foreach (dibits[d]) begin
      repeat (HOLD) exp_q.push_back({1'b1, dibits[d]});
      repeat (GAP) exp_q.push_back(3'b000);
    end
  endtask

  // Enters and leaves at a falling edge with the DUT idle.
  task automatic send_byte(input logic [7:0] b, input bit scramble, input string nm);
    n_checks++;
    if (bus.data_ready !== 1'b1) $display("FAIL %s ready_before got %b want 1", nm, bus.data_ready);
    else n_pass++;
    bus.data_in = b;
    bus.data_valid = 1'b1;
    build_expected(b);
    @(negedge clk);
    bus.data_valid = 1'b0;
    foreach (exp_q[k]) begin
      n_checks++;
      if (bus.rl_signal !== exp_q[k] || bus.data_ready !== 1'b0 || bus.busy !== 1'b1)
        $display("FAIL %s cyc%0d rl/ready/busy got %b/%b/%b want %b/0/1",
                 nm, k, bus.rl_signal, bus.data_ready, bus.busy, exp_q[k]);
      else n_pass++;
      if (scramble) begin
        bus.data_in = 8'($urandom);
        bus.data_valid = 1'($urandom);
      end
      @(negedge clk);
    end
    bus.data_valid = 1'b0;
    n_checks++;
    if (b == 8'hFF) begin
      if (bus.end_seen !== 1'b1 || bus.data_ready !== 1'b0 || bus.busy !== 1'b1 || bus.rl_signal !== 3'b000)
        $display("FAIL %s end_state end/ready/busy/rl got %b/%b/%b/%b want 1/0/1/000",
                 nm, bus.end_seen, bus.data_ready, bus.busy, bus.rl_signal);
      else n_pass++;
    end else begin
      if (bus.end_seen !== 1'b0 || bus.data_ready !== 1'b1 || bus.busy !== 1'b0 || bus.rl_signal !== 3'b000)
        $display("FAIL %s idle_after end/ready/busy/rl got %b/%b/%b/%b want 0/1/0/000",
                 nm, bus.end_seen, bus.data_ready, bus.busy, bus.rl_signal);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.rl_signal !== 3'b000 || bus.data_ready !== 1'b1 || bus.busy !== 1'b0 || bus.end_seen !== 1'b0)
      $display("FAIL reset rl/ready/busy/end got %b/%b/%b/%b want 000/1/0/0",
               bus.rl_signal, bus.data_ready, bus.busy, bus.end_seen);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.data_ready !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL reset_release ready/busy got %b/%b want 1/0", bus.data_ready, bus.busy);
    else n_pass++;
  endtask

  task automatic test_single_byte();
    send_byte(8'hB4, 1'b0, "byte_b4");
    for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 254)), 1'b0, "byte_rand");
  endtask

  task automatic test_back_to_back();
    bus.data_in = 8'h12;
    bus.data_valid = 1'b1;
    build_expected(8'h12);
    @(negedge clk);
    bus.data_in = 8'hFF;
    foreach (exp_q[k]) begin
      n_checks++;
      if (bus.rl_signal !== exp_q[k] || bus.data_ready !== 1'b0)
        $display("FAIL b2b_12 cyc%0d rl/ready got %b/%b want %b/0", k, bus.rl_signal, bus.data_ready, exp_q[k]);
      else n_pass++;
      @(negedge clk);
    end
    n_checks++;
    if (bus.data_ready !== 1'b1) $display("FAIL b2b_ready_rise got %b want 1", bus.data_ready);
    else n_pass++;
    build_expected(8'hFF);
    @(negedge clk);
    bus.data_valid = 1'b0;
    foreach (exp_q[k]) begin
      n_checks++;
      if (bus.rl_signal !== exp_q[k] || bus.data_ready !== 1'b0)
        $display("FAIL b2b_ff cyc%0d rl/ready got %b/%b want %b/0", k, bus.rl_signal, bus.data_ready, exp_q[k]);
      else n_pass++;
      @(negedge clk);
    end
    repeat (3) begin
      n_checks++;
      if (bus.end_seen !== 1'b1 || bus.data_ready !== 1'b0 || bus.rl_signal !== 3'b000 || bus.busy !== 1'b1)
        $display("FAIL b2b_end end/ready/rl/busy got %b/%b/%b/%b want 1/0/000/1",
                 bus.end_seen, bus.data_ready, bus.rl_signal, bus.busy);
      else n_pass++;
      @(negedge clk);
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    n_checks++;
    if (bus.end_seen !== 1'b0 || bus.data_ready !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL end_abort end/ready/busy got %b/%b/%b want 0/1/0", bus.end_seen, bus.data_ready, bus.busy);
    else n_pass++;
  endtask

  task automatic test_abort();
    bus.data_in = 8'hB4;
    bus.data_valid = 1'b1;
    build_expected(8'hB4);
    @(negedge clk);
    bus.data_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (bus.rl_signal !== exp_q[k]) $display("FAIL abort_pre cyc%0d rl got %b want %b", k, bus.rl_signal, exp_q[k]);
      else n_pass++;
      if (k < 7) @(negedge clk);
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    n_checks++;
    if (bus.rl_signal !== 3'b000 || bus.data_ready !== 1'b1 || bus.busy !== 1'b0 || bus.end_seen !== 1'b0)
      $display("FAIL abort_mark rl/ready/busy/end got %b/%b/%b/%b want 000/1/0/0",
               bus.rl_signal, bus.data_ready, bus.busy, bus.end_seen);
    else n_pass++;
    send_byte(8'($urandom_range(0, 254)), 1'b0, "after_abort");
    // abort wins over a simultaneous offer
    bus.abort = 1'b1;
    bus.data_valid = 1'b1;
    bus.data_in = 8'h5A;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.data_valid = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.data_ready !== 1'b1 || bus.rl_signal !== 3'b000)
      $display("FAIL abort_priority busy/ready/rl got %b/%b/%b want 0/1/000", bus.busy, bus.data_ready, bus.rl_signal);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bus.data_in = 8'($urandom_range(0, 254));
    bus.data_valid = 1'b1;
    build_expected(bus.data_in);
    @(negedge clk);
    bus.data_valid = 1'b0;
    for (int k = 0; k < 17; k++) begin
      n_checks++;
      if (bus.rl_signal !== exp_q[k]) $display("FAIL rst_pre cyc%0d rl got %b want %b", k, bus.rl_signal, exp_q[k]);
      else n_pass++;
      if (k < 16) @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (bus.rl_signal !== 3'b000 || bus.data_ready !== 1'b1 || bus.busy !== 1'b0 || bus.end_seen !== 1'b0)
      $display("FAIL rst_space rl/ready/busy/end got %b/%b/%b/%b want 000/1/0/0",
               bus.rl_signal, bus.data_ready, bus.busy, bus.end_seen);
    else n_pass++;
    send_byte(8'hFF, 1'b0, "to_end");
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (bus.rl_signal !== 3'b000 || bus.data_ready !== 1'b1 || bus.busy !== 1'b0 || bus.end_seen !== 1'b0)
      $display("FAIL rst_end rl/ready/busy/end got %b/%b/%b/%b want 000/1/0/0",
               bus.rl_signal, bus.data_ready, bus.busy, bus.end_seen);
    else n_pass++;
    send_byte(8'h3C, 1'b0, "after_rst");
  endtask

  task automatic test_ignore_inputs();
    send_byte(8'hB4, 1'b1, "scramble_b4");
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 254)), 1'b1, "scramble_rand");
  endtask

`ifdef RL_WRITER_PARITY_EN
  task automatic test_parity();
    logic [2:0] want;
    bus.data_in = 8'h07;
    bus.data_valid = 1'b1;
    build_expected(8'h07);
    @(negedge clk);
    bus.data_valid = 1'b0;
    for (int k = 0; k < 30; k++) begin
      want = (k < 24) ? exp_q[k] : ((k < 28) ? 3'b101 : 3'b000);
      n_checks++;
      if (bus.rl_signal !== want) $display("FAIL parity_07 cyc%0d rl got %b want %b", k, bus.rl_signal, want);
      else n_pass++;
      @(negedge clk);
    end
    n_checks++;
    if (bus.data_ready !== 1'b1) $display("FAIL parity_len ready got %b want 1", bus.data_ready);
    else n_pass++;
  endtask
`endif

  initial begin
    bus.data_in = 8'h00;
    bus.data_valid = 1'b0;
    bus.abort = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_ignore_inputs();
`ifdef RL_WRITER_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d checks", n_checks);
    $fatal(1, "watchdog");
  end
endmodule
